// File: rtl/bin_to_gray_counter.sv
// Binary counter with a registered Gray-coded copy for clock-domain-crossing pointers.
// Optional down counting (dir port) is enabled by defining BIN_TO_GRAY_COUNTER_DOWN_EN.
module bin_to_gray_counter #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en,
`ifdef BIN_TO_GRAY_COUNTER_DOWN_EN
  input  logic                  dir,
`endif
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_val,
  output logic [DATA_WIDTH-1:0] bin,
  output logic [DATA_WIDTH-1:0] gray,
  output logic                  wrap
);

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  logic [DATA_WIDTH-1:0] bin_q, bin_d;
  logic [DATA_WIDTH-1:0] gray_q, gray_d;
  logic                  wrap_q, wrap_d;

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_val;
    end else if (en) begin
`ifdef BIN_TO_GRAY_COUNTER_DOWN_EN
      if (dir) begin
        bin_d  = bin_q - ONE;
        wrap_d = ~|bin_q;
      end else begin
        bin_d  = bin_q + ONE;
        wrap_d = &bin_q;
      end
`else
      bin_d  = bin_q + ONE;
      wrap_d = &bin_q;
`endif
    end
    // Encode from the next binary value so gray and bin update on the same edge.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_bin_to_gray_counter.sv
// Directed, table-driven bench for bin_to_gray_counter at DATA_WIDTH=4.
module tb_bin_to_gray_counter;

  localparam int W = 4;

  logic         clk;
  logic         resetn;
  logic         en;
  logic         dir;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] bin;
  logic [W-1:0] gray;
  logic         wrap;

  int checks   = 0;
  int failures = 0;

  bin_to_gray_counter #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .en       (en),
`ifdef BIN_TO_GRAY_COUNTER_DOWN_EN
    .dir      (dir),
`endif
    .load     (load),
    .load_val (load_val),
    .bin      (bin),
    .gray     (gray),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         load;
    logic         en;
    logic [W-1:0] load_val;
    logic [W-1:0] exp_bin;
    logic [W-1:0] exp_gray;
    logic         exp_wrap;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input logic [W-1:0] eb, input logic [W-1:0] eg,
                           input logic ew);
    check({name, ".bin"}, 32'(bin), 32'(eb));
    check({name, ".gray"}, 32'(gray), 32'(eg));
    check({name, ".wrap"}, 32'(wrap), 32'(ew));
  endtask

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Inputs are set at a negedge; results are sampled at the following negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] gseq [16];
    logic [W-1:0] prev_gray;

    gseq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
             4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    for (int i = 0; i < 16; i++)
      vecs[i] = '{1'b0, 1'b1, 4'h0, 4'((i + 1) % 16), gseq[i], (i == 15)};
    vecs[16] = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 4'hA, 4'hA, 4'hF, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 4'hA, 4'hA, 4'hF, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 4'h0, 4'hB, 4'hE, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 4'hF, 4'hF, 4'h8, 1'b0};
    vecs[21] = '{1'b1, 1'b1, 4'hF, 4'hF, 4'h8, 1'b0};
    vecs[22] = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1};
    vecs[23] = '{1'b0, 1'b1, 4'h0, 4'h1, 4'h1, 1'b0};

    resetn = 1'b0; en = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
    #1;
    check_all("reset_no_clk", 4'h0, 4'h0, 1'b0);

    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_all("idle", 4'h0, 4'h0, 1'b0);
    end

    prev_gray = gray;
    for (int i = 0; i < 24; i++) begin
      load = vecs[i].load; en = vecs[i].en; load_val = vecs[i].load_val;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].exp_bin, vecs[i].exp_gray, vecs[i].exp_wrap);
      if (i < 16) check($sformatf("hamming%0d", i), 32'($countones(gray ^ prev_gray)), 32'd1);
      prev_gray = gray;
    end

    // Asynchronous reset mid-count at bin=7, away from any clock edge.
    load = 1'b1; en = 1'b0; load_val = 4'h7;
    step();
    load = 1'b0; en = 1'b1;
    check_all("pre_reset", 4'h7, 4'h4, 1'b0);
    #2 resetn = 1'b0;
    #1 check_all("async_reset", 4'h0, 4'h0, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    step();
    check_all("after_reset", 4'h1, 4'h1, 1'b0);

    // Reset during a wrap pulse drops it and leaves no pending pulse.
    load = 1'b1; load_val = 4'hF;
    step();
    load = 1'b0; en = 1'b1;
    step();
    check_all("wrap_pulse", 4'h0, 4'h0, 1'b1);
    en = 1'b0;
    #2 resetn = 1'b0;
    #1 check_all("reset_in_wrap", 4'h0, 4'h0, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    step();
    check_all("no_pending_wrap", 4'h0, 4'h0, 1'b0);

`ifdef BIN_TO_GRAY_COUNTER_DOWN_EN
    begin
      logic [W-1:0] exp_b;
      dir = 1'b1; en = 1'b1;
      step();
      check_all("down_wrap", 4'hF, 4'h8, 1'b1);
      step();
      check_all("down_14", 4'hE, 4'h9, 1'b0);
      step();
      check_all("down_13", 4'hD, 4'hB, 1'b0);
      exp_b = 4'hD;
      prev_gray = gray;
      for (int i = 0; i < 14; i++) begin
        step();
        exp_b = exp_b - 4'h1;
        check("down_bin", 32'(bin), 32'(exp_b));
        check("down_g2b", 32'(g2b(gray)), 32'(exp_b));
        check("down_hamming", 32'($countones(gray ^ prev_gray)), 32'd1);
        check("down_wrap_flag", 32'(wrap), 32'(exp_b == 4'hF));
        prev_gray = gray;
      end
      dir = 1'b0; en = 1'b0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
